// File: rtl/try_funct_pkg.sv
// Shared constants and factorial helper for the try_funct arithmetic demo.
// Latency: n/a (package only).
// Backpressure: none (package only).
package try_funct_pkg;

    localparam int N_W    = 4;
    localparam int RES_W  = 32;
    localparam int CALC_W = 64;

    // Iterative factorial; the loop bound is fixed so it unrolls to a constant-depth multiplier chain.
    function automatic logic [CALC_W-1:0] fact(input logic [N_W-1:0] k);
        logic [CALC_W-1:0] acc;
        acc = CALC_W'(1);
        for (int i = 1; i < (2 ** N_W); i++) begin
            if (i <= int'(k)) begin
                acc = acc * CALC_W'(i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/try_funct_calc.sv
// Combinational f(n) = floor(n * n! / (2n + 1)) at full 64-bit width.
// Latency: 0 clocks (pure combinational).
// Backpressure: none; output follows n continuously.
module try_funct_calc
    import try_funct_pkg::*;
(
    input  logic [N_W-1:0]    n,
    output logic [CALC_W-1:0] f
);

    logic [CALC_W-1:0] w_fact;
    logic [CALC_W-1:0] w_prod;
    logic [CALC_W-1:0] w_div;

    // n! fits easily in 64 bits for n <= 15, and so does n * n!.
    assign w_fact = fact(n);
    assign w_prod = w_fact * CALC_W'(n);
    // 2n+1 is n shifted left with a 1 in the LSB, so it is never zero.
    assign w_div  = CALC_W'({n, 1'b1});
    assign f      = w_prod / w_div;

endmodule

// File: rtl/try_funct.sv
// Registered lookup of f(n) = floor(n * n! / (2n + 1)), low 32 bits kept.
// Latency: 1 clock from n to result; reset==0 clears result asynchronously.
// Backpressure: none; n is sampled on every rising edge.
module try_funct
    import try_funct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_W-1:0]   n,
    output logic [RES_W-1:0] result
);

    logic [CALC_W-1:0] w_f;
    logic [RES_W-1:0]  r_result;

    try_funct_calc u_calc (
        .n (n),
        .f (w_f)
    );

    // Result register: cleared while reset is low, otherwise loads the truncated quotient.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
        end else begin
            r_result <= RES_W'(w_f);
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_try_funct.sv
// Directed bench for try_funct: reset behaviour, full operand sweep, truncation and sampling edge.
// Latency: expects result one clock after n is applied.
// Backpressure: none.
module tb_try_funct;

    logic        clk;
    logic        reset;
    logic [3:0]  n;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    try_funct dut (
        .clk    (clk),
        .reset  (reset),
        .n      (n),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Hand-computed floor(n*n!/(2n+1)) mod 2^32.
    function automatic logic [31:0] exp_tab(input int k);
        case (k)
            0:  return 32'd0;
            1:  return 32'd0;
            2:  return 32'd0;
            3:  return 32'd2;
            4:  return 32'd10;
            5:  return 32'd54;
            6:  return 32'd332;
            7:  return 32'd2352;
            8:  return 32'd18974;
            9:  return 32'd171890;
            10: return 32'd1728000;
            11: return 32'd19090643;
            12: return 32'd229920768;
            13: return 32'd2998195200;
            14: return 32'd3431365949;
            15: return 32'd1385469423;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Independent 64-bit reference of the formula, computed by recursion.
    function automatic logic [63:0] ref_fact(input int k);
        if (k <= 1) return 64'd1;
        return 64'(k) * ref_fact(k - 1);
    endfunction

    function automatic logic [31:0] ref_f(input int k);
        logic [63:0] q;
        q = (64'(k) * ref_fact(k)) / 64'(2 * k + 1);
        return q[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        // Reset held low with the clock running: result must stay 0.
        reset = 1'b0;
        n     = 4'd7;
        #1;
        check("reset_initial", result, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", result, 32'd0);

        // Release between edges; first edge loads f(7).
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_no_edge", result, 32'd0);
        @(posedge clk);
        #1;
        check("first_load_n7", result, 32'd2352);

        // Sweep every operand, two clocks per value.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n = 4'(i);
            @(posedge clk);
            #1;
            check($sformatf("sweep_tab_n%0d", i), result, exp_tab(i));
            @(posedge clk);
            #1;
            check($sformatf("sweep_ref_n%0d", i), result, ref_f(i));
        end

        // Truncation of 632745661935 to 32 bits.
        @(negedge clk);
        n = 4'd15;
        @(posedge clk);
        #1;
        check("trunc_n15", result, 32'd1385469423);

        // Asynchronous reset mid-cycle.
        @(negedge clk);
        n = 4'd10;
        @(posedge clk);
        #1;
        check("pre_async_n10", result, 32'd1728000);
        #20;
        reset = 1'b0;
        #1;
        check("async_clear", result, 32'd0);
        @(negedge clk);
        check("async_hold", result, 32'd0);
        reset = 1'b1;
        #1;
        check("async_release_no_edge", result, 32'd0);
        @(posedge clk);
        #1;
        check("async_reload_n10", result, 32'd1728000);

        // n changes just after an edge: only the next edge samples it.
        @(negedge clk);
        n = 4'd3;
        @(posedge clk);
        #1;
        check("sample_n3", result, 32'd2);
        #5;
        n = 4'd4;
        #10;
        check("midcycle_hold", result, 32'd2);
        @(negedge clk);
        check("midcycle_hold_neg", result, 32'd2);
        @(posedge clk);
        #1;
        check("sample_n4", result, 32'd10);
        check("sample_n4_ref", result, ref_f(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
